nrf_spi_master: RTL and testbench
=================================

# nrf_spi_master

Byte-level SPI master (mode 0: CPOL=0, CPHA=0, MSB first) that sits directly downstream of the nRF24L01 controller. It turns the controller's `spi_start`/`spi_tx_data` request into one 8-bit full-duplex transfer on SCK/MOSI/MISO/CSN. It returns the received byte on `spi_rx_data` and reports progress on `spi_busy`. CSN can be held low across consecutive bytes so that multi-byte nRF24L01 commands (command byte plus payload) form one transaction.

## Interface
Parameters:
- CLK_DIV, 4: SCK half-period in clk cycles; must be ≥1.
- CS_SETUP, 2: clk cycles from the CSN falling edge to the start of the first SCK low phase; must be ≥1.
- CS_IDLE, 2: minimum clk cycles CSN stays high after a non-held byte before the block returns to idle; must be ≥0 (0 skips the GAP state).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- spi_start  in  1  level request; sampled only in IDLE.
- spi_tx_data  in  8  byte to send; captured on acceptance.
- spi_hold  in  1  keep CSN low after this byte; captured on acceptance.
- spi_rx_data  out  8  last received byte; holds its value until the next byte completes.
- spi_busy  out  1  high from acceptance until the block is back in IDLE.
- spi_done  out  1  one-cycle pulse when a byte completes.
- sck  out  1  SPI clock, idles low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- csn  out  1  chip select, active-low.

## Operation
- Reset (async): state IDLE, csn=1, sck=0, mosi=0, spi_busy=0, spi_done=0, spi_rx_data=0x00, all counters 0. Reset mid-transfer aborts the byte immediately with no done pulse.
- Acceptance: state IDLE and spi_start=1 at a clk edge.
  - At that edge: capture tx byte and hold flag; busy←1; csn←0; mosi←tx[7]; bit_cnt←0.
  - Next state is SETUP if csn was high, or LOW if csn was already held low.
- SETUP: sck=0 for CS_SETUP cycles, then go to LOW.
- LOW: sck=0 for CLK_DIV cycles. At the end: sck←1, rx_sr←{rx_sr[6:0], miso} using the miso value sampled at that edge, go to HIGH.
- HIGH: sck=1 for CLK_DIV cycles. At the end: sck←0.
  - If bit_cnt<7: bit_cnt+1, mosi←next tx bit, go to LOW.
  - If bit_cnt=7 (byte end): spi_rx_data←rx_sr, spi_done←1 for one cycle.
    - Hold=1: csn stays 0, busy←0, go to IDLE.
    - Hold=0: csn←1, mosi←0, go to GAP (or directly to IDLE with busy←0 if CS_IDLE=0).
- GAP: csn=1 for CS_IDLE cycles, then busy←0 and go to IDLE.
- spi_start or spi_tx_data changing while busy is ignored and has no effect on the byte in flight.
- A spi_start held high produces back-to-back bytes. The next acceptance occurs one cycle after busy falls.
- A held CSN stays low indefinitely in IDLE until the next non-held byte completes or reset.

## Timing
- Acceptance edge = cycle 0.
  - First SCK rise at cycle CS_SETUP+CLK_DIV, or CLK_DIV when CSN was held.
  - SCK edges follow every CLK_DIV cycles; 16 edges per byte.
  - Done edge at CS_SETUP+16·CLK_DIV, or 16·CLK_DIV when CSN was held.
- Defaults: first rise 6, last fall/done 66, busy falls 68 (busy high 68 cycles).
- The minimum CSN-high time between back-to-back non-held bytes is CS_IDLE+1 cycles.
- MOSI is stable for CLK_DIV cycles before every SCK rise.
- Counter widths are $clog2 of the largest parameter (min 1). bit_cnt is 3 bits and never wraps mid-byte.

## Structure
- Shared package nrf_pkg holds:
  - the state encoding (IDLE, SETUP, LOW, HIGH, GAP);
  - default timing constants (NRF_CLK_DIV, NRF_CS_SETUP, NRF_CS_IDLE);
  - common nRF24L01 command bytes (e.g. W_REGISTER base 0x20, NOP 0xFF).
- One sub-module is natural: nrf_spi_tick, a loadable down-counter that produces the phase-end strobe for SETUP/LOW/HIGH/GAP. The shift registers and FSM stay in the top.

## Test plan
- All tests use default parameters and a slave model that drives miso on SCK falls.
- Single byte: tx 0x08, slave returns 0xA5 → MOSI sampled at rises = 0,0,0,0,1,0,0,0; spi_rx_data=0xA5 and spi_done=1 at cycle 66 only; csn high at 66; busy low at 68.
- Held CSN: tx 0x20 hold=1, then 0xFF hold=0 → csn never rises between bytes; second byte's first SCK rise 4 cycles after acceptance; csn rises at its done edge.
- spi_start tied high with 0x08 → consecutive bytes with csn high for exactly 3 cycles between them; each byte 68 busy cycles.
- Change spi_tx_data to 0xFF and pulse spi_start mid-byte → MOSI pattern and rx unaffected; no extra transaction.
- Reset asserted at cycle 30 → csn=1, sck=0, busy=0, rx=0x00 immediately with no done pulse; after release, a new 0x3C/0xC3 exchange completes correctly.
- CLK_DIV=1, CS_SETUP=1, CS_IDLE=0 → first rise at cycle 2, done at 17, busy low at 17, and no GAP cycle.

Source files
------------

// File: rtl/nrf_pkg.sv
// Shared definitions for the nRF24L01 SPI path: FSM encoding, default
// timing constants, command bytes and a counter-width helper.
package nrf_pkg;

    // Default timing, in clk cycles
    localparam int NRF_CLK_DIV  = 4;
    localparam int NRF_CS_SETUP = 2;
    localparam int NRF_CS_IDLE  = 2;

    // SPI master FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // Common nRF24L01 command bytes
    localparam logic [7:0] NRF_CMD_R_REGISTER   = 8'h00;
    localparam logic [7:0] NRF_CMD_W_REGISTER   = 8'h20;
    localparam logic [7:0] NRF_CMD_R_RX_PAYLOAD = 8'h61;
    localparam logic [7:0] NRF_CMD_W_TX_PAYLOAD = 8'hA0;
    localparam logic [7:0] NRF_CMD_FLUSH_TX     = 8'hE1;
    localparam logic [7:0] NRF_CMD_FLUSH_RX     = 8'hE2;
    localparam logic [7:0] NRF_CMD_NOP          = 8'hFF;

    // Phase counter width: clog2 of the largest timing parameter, at least 1
    function automatic int nrf_cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nrf_spi_master_if.sv
// Byte-request handshake between the nRF24L01 controller and the SPI master.
interface nrf_spi_master_if;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic       spi_hold;
    logic [7:0] spi_rx_data;
    logic       spi_busy;
    logic       spi_done;

    // Controller side: issues requests, observes results
    modport master (
        output spi_start, spi_tx_data, spi_hold,
        input  spi_rx_data, spi_busy, spi_done
    );

    // SPI master side: accepts requests, returns results
    modport slave (
        input  spi_start, spi_tx_data, spi_hold,
        output spi_rx_data, spi_busy, spi_done
    );
endinterface

// File: rtl/nrf_spi_tick.sv
// Loadable down-counter; tick is high while the count sits at zero, which
// marks the last cycle of the current SPI phase.
module nrf_spi_tick #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    // Reload on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/nrf_spi_master.sv
// Byte-level SPI master, mode 0, MSB first. CSN may be held low across
// bytes so multi-byte nRF24L01 commands form a single transaction.
module nrf_spi_master
    import nrf_pkg::*;
#(
    parameter int CLK_DIV  = NRF_CLK_DIV,
    parameter int CS_SETUP = NRF_CS_SETUP,
    parameter int CS_IDLE  = NRF_CS_IDLE
) (
    input  logic             clk,
    input  logic             reset,
    nrf_spi_master_if.slave  bus,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic             csn
);

    localparam int CNT_W = nrf_cnt_width(CLK_DIV, CS_SETUP, CS_IDLE);
    localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'((CS_IDLE > 0) ? CS_IDLE - 1 : 0);

    logic [2:0]       state;
    logic [6:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic [7:0]       rx_data_r;
    logic [2:0]       bit_cnt;
    logic             hold_r;
    logic             busy_r;
    logic             done_r;
    logic             tick_load;
    logic [CNT_W-1:0] tick_val;
    logic             tick_done;

    assign bus.spi_rx_data = rx_data_r;
    assign bus.spi_busy    = busy_r;
    assign bus.spi_done    = done_r;

    nrf_spi_tick #(.WIDTH(CNT_W)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .load     (tick_load),
        .load_val (tick_val),
        .tick     (tick_done)
    );

    // Reload the phase counter whenever the FSM enters a timed state
    always_comb begin
        tick_load = 1'b0;
        tick_val  = '0;
        case (state)
            ST_IDLE: begin
                if (bus.spi_start) begin
                    tick_load = 1'b1;
                    tick_val  = csn ? SETUP_LD : DIV_LD;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (tick_done) begin
                    tick_load = 1'b1;
                    tick_val  = DIV_LD;
                end
            end
            ST_HIGH: begin
                if (tick_done) begin
                    if (bit_cnt != 3'd7) begin
                        tick_load = 1'b1;
                        tick_val  = DIV_LD;
                    end else if (!hold_r && CS_IDLE != 0) begin
                        tick_load = 1'b1;
                        tick_val  = IDLE_LD;
                    end
                end
            end
            default: begin
                tick_load = 1'b0;
            end
        endcase
    end

    // Transfer FSM with shift registers and SPI pin drivers.
    // tx_sr keeps only bits 6:0: bit 7 goes straight to mosi on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            csn       <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rx_data_r <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            hold_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.spi_start) begin
                        tx_sr   <= bus.spi_tx_data[6:0];
                        hold_r  <= bus.spi_hold;
                        busy_r  <= 1'b1;
                        csn     <= 1'b0;
                        mosi    <= bus.spi_tx_data[7];
                        bit_cnt <= '0;
                        state   <= csn ? ST_SETUP : ST_LOW;
                    end
                end
                ST_SETUP: begin
                    if (tick_done) state <= ST_LOW;
                end
                ST_LOW: begin
                    if (tick_done) begin
                        sck   <= 1'b1;
                        rx_sr <= {rx_sr[6:0], miso};
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick_done) begin
                        sck <= 1'b0;
                        if (bit_cnt != 3'd7) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            mosi    <= tx_sr[6];
                            tx_sr   <= {tx_sr[5:0], 1'b0};
                            state   <= ST_LOW;
                        end else begin
                            rx_data_r <= rx_sr;
                            done_r    <= 1'b1;
                            if (hold_r) begin
                                busy_r <= 1'b0;
                                state  <= ST_IDLE;
                            end else begin
                                csn  <= 1'b1;
                                mosi <= 1'b0;
                                if (CS_IDLE == 0) begin
                                    busy_r <= 1'b0;
                                    state  <= ST_IDLE;
                                end else begin
                                    state <= ST_GAP;
                                end
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (tick_done) begin
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrf_spi_master.sv
// Self-checking bench for nrf_spi_master: a mode-0 slave model plus
// expected timing derived from the phase lengths.
module tb_nrf_spi_master;
    import nrf_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nrf_spi_master_if bus ();
    nrf_spi_master_if bus2 ();

    logic sck, mosi, csn;
    logic miso = 1'b0;
    logic sck2, mosi2, csn2;
    logic miso2 = 1'b0;

    nrf_spi_master #(
        .CLK_DIV  (NRF_CLK_DIV),
        .CS_SETUP (NRF_CS_SETUP),
        .CS_IDLE  (NRF_CS_IDLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .sck   (sck),
        .mosi  (mosi),
        .miso  (miso),
        .csn   (csn)
    );

    nrf_spi_master #(
        .CLK_DIV  (1),
        .CS_SETUP (1),
        .CS_IDLE  (0)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave),
        .sck   (sck2),
        .mosi  (mosi2),
        .miso  (miso2),
        .csn   (csn2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    // Slave model: responses queued per byte, miso shifted out on SCK falls,
    // mosi captured on SCK rises.
    logic [7:0] resp_q [$];
    logic [7:0] s_byte = 8'h00;
    logic [7:0] s_rx   = 8'h00;
    int         s_cnt  = 0;
    int         s_bit  = 0;
    int         csn_falls = 0;
    int         hi_run = 0;
    int         last_hi = 0;
    logic       csn_q = 1'b1;
    logic       sck_q = 1'b0;

    function automatic logic [7:0] pop_resp();
        if (resp_q.size() > 0) return resp_q.pop_front();
        return 8'hFF;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (csn_q && !csn) begin
                csn_falls++;
                s_cnt  = 0;
                s_bit  = 0;
                s_byte = pop_resp();
            end
            if (!sck_q && sck) begin
                s_rx = {s_rx[6:0], mosi};
                s_cnt++;
            end
            if (sck_q && !sck) begin
                s_bit = s_cnt % 8;
                if (s_bit == 0 && !csn) s_byte = pop_resp();
            end
            miso = s_byte[7 - s_bit];
            if (csn) begin
                hi_run++;
            end else begin
                if (hi_run != 0) last_hi = hi_run;
                hi_run = 0;
            end
            csn_q = csn;
            sck_q = sck;
        end
    end

    // One byte on the default-parameter DUT, checked against expected timing
    task automatic do_byte(input logic [7:0] tx, input logic hold, input logic [7:0] resp,
                           input logic held_in, input logic keep_start, input logic disturb,
                           input string tag);
        int         rel;
        int         first_rise;
        int         rises;
        int         dones;
        int         done_rel;
        int         busy_fall;
        int         pre;
        logic       sck_p;
        logic       csn_bad;
        logic       done_seen;
        logic [7:0] rx_at_done;
        logic [7:0] mosi_at_done;
        pre = held_in ? 0 : NRF_CS_SETUP;
        @(negedge clk);
        bus.spi_start   = 1'b1;
        bus.spi_tx_data = tx;
        bus.spi_hold    = hold;
        @(posedge clk);
        #1;
        check(tag, "accept_busy", bus.spi_busy, 1);
        check(tag, "accept_csn", csn, 0);
        if (!keep_start) bus.spi_start = 1'b0;
        rel = 0; first_rise = -1; rises = 0; dones = 0; done_rel = -1; busy_fall = -1;
        sck_p = sck; csn_bad = 1'b0; done_seen = 1'b0;
        rx_at_done = 8'h00; mosi_at_done = 8'h00;
        while (rel < 300) begin
            @(posedge clk);
            #1;
            rel++;
            if (disturb && rel == 20) begin
                bus.spi_tx_data = 8'hFF;
                bus.spi_start   = 1'b1;
            end
            if (disturb && rel == 21) bus.spi_start = 1'b0;
            if (sck && !sck_p) begin
                rises++;
                if (first_rise < 0) first_rise = rel;
            end
            sck_p = sck;
            if (bus.spi_done) begin
                dones++;
                done_rel     = rel;
                rx_at_done   = bus.spi_rx_data;
                mosi_at_done = s_rx;
                done_seen    = 1'b1;
            end
            if (csn !== ((!hold && done_seen) ? 1'b1 : 1'b0)) csn_bad = 1'b1;
            if (!bus.spi_busy) begin
                busy_fall = rel;
                break;
            end
        end
        check(tag, "first_rise", first_rise, pre + NRF_CLK_DIV);
        check(tag, "rises", rises, 8);
        check(tag, "done_count", dones, 1);
        check(tag, "done_cycle", done_rel, pre + 16 * NRF_CLK_DIV);
        check(tag, "rx_at_done", rx_at_done, resp);
        check(tag, "mosi_bits", mosi_at_done, tx);
        check(tag, "csn_profile", csn_bad, 0);
        check(tag, "busy_fall", busy_fall,
              pre + 16 * NRF_CLK_DIV + (hold ? 0 : NRF_CS_IDLE));
        check(tag, "rx_hold", bus.spi_rx_data, resp);
    endtask

    // Measure one byte on the CLK_DIV=1/CS_SETUP=1/CS_IDLE=0 DUT after acceptance
    task automatic measure2(input logic [7:0] tx, input logic [7:0] exp_rx, input string tag);
        int         rel;
        int         first_rise;
        int         done_rel;
        int         busy_fall;
        logic       sck_p;
        logic [7:0] m;
        logic [7:0] rx_at_done;
        rel = 0; first_rise = -1; done_rel = -1; busy_fall = -1;
        sck_p = sck2; m = 8'h00; rx_at_done = 8'h00;
        while (rel < 100) begin
            @(posedge clk);
            #1;
            rel++;
            if (sck2 && !sck_p) begin
                m = {m[6:0], mosi2};
                if (first_rise < 0) first_rise = rel;
            end
            sck_p = sck2;
            if (bus2.spi_done) begin
                done_rel   = rel;
                rx_at_done = bus2.spi_rx_data;
            end
            if (!bus2.spi_busy) begin
                busy_fall = rel;
                break;
            end
        end
        check(tag, "first_rise", first_rise, 2);
        check(tag, "done_cycle", done_rel, 17);
        check(tag, "busy_fall", busy_fall, 17);
        check(tag, "csn_at_done", csn2, 1);
        check(tag, "rx", rx_at_done, exp_rx);
        check(tag, "mosi_bits", m, tx);
    endtask

    logic [7:0] rtx [6];
    logic [7:0] rrs [6];
    logic       rh  [6];
    logic       prev_hold;
    logic [7:0] tmp_tx;
    logic [7:0] tmp_rs;
    logic [7:0] tx_a;
    logic [7:0] tx_b;
    int         falls0;
    int         rdones;

    initial begin
        bus.spi_start    = 1'b0;
        bus.spi_tx_data  = 8'h00;
        bus.spi_hold     = 1'b0;
        bus2.spi_start   = 1'b0;
        bus2.spi_tx_data = 8'h00;
        bus2.spi_hold    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", "csn", csn, 1);
        check("reset", "sck", sck, 0);
        check("reset", "mosi", mosi, 0);
        check("reset", "busy", bus.spi_busy, 0);
        check("reset", "done", bus.spi_done, 0);
        check("reset", "rx", bus.spi_rx_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Single byte
        resp_q.push_back(8'hA5);
        do_byte(8'h08, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, "single");

        // Held CSN across a two-byte command
        tmp_rs = 8'($urandom);
        resp_q.push_back(8'h5A);
        resp_q.push_back(tmp_rs);
        falls0 = csn_falls;
        do_byte(8'h20, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, "held_cmd");
        do_byte(8'hFF, 1'b0, tmp_rs, 1'b1, 1'b0, 1'b0, "held_data");
        check("held", "csn_falls", csn_falls - falls0, 1);

        // spi_start tied high: back-to-back bytes
        resp_q.push_back(8'h3E);
        resp_q.push_back(8'hC1);
        do_byte(8'h08, 1'b0, 8'h3E, 1'b0, 1'b1, 1'b0, "tied_a");
        do_byte(8'h08, 1'b0, 8'hC1, 1'b0, 1'b0, 1'b0, "tied_b");
        check("tied", "csn_high_gap", last_hi, NRF_CS_IDLE + 1);

        // Request changes while busy are ignored
        tmp_tx = 8'($urandom);
        tmp_rs = 8'($urandom) | 8'h01;
        resp_q.push_back(tmp_rs);
        falls0 = csn_falls;
        do_byte(tmp_tx, 1'b0, tmp_rs, 1'b0, 1'b0, 1'b1, "disturb");
        repeat (5) @(posedge clk);
        #1;
        check("disturb", "idle_busy", bus.spi_busy, 0);
        check("disturb", "idle_csn", csn, 1);
        check("disturb", "no_extra_txn", csn_falls - falls0, 1);

        // Reset mid-byte
        resp_q.push_back(8'h99);
        @(negedge clk);
        bus.spi_start   = 1'b1;
        bus.spi_tx_data = 8'h3C;
        bus.spi_hold    = 1'b0;
        @(posedge clk);
        #1;
        bus.spi_start = 1'b0;
        rdones = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.spi_done) rdones++;
        end
        reset = 1'b1;
        #1;
        check("abort", "csn", csn, 1);
        check("abort", "sck", sck, 0);
        check("abort", "mosi", mosi, 0);
        check("abort", "busy", bus.spi_busy, 0);
        check("abort", "rx", bus.spi_rx_data, 8'h00);
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.spi_done) rdones++;
        end
        check("abort", "no_done", rdones, 0);
        @(negedge clk);
        reset = 1'b0;
        resp_q.push_back(8'hC3);
        do_byte(8'h3C, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, "post_reset");

        // Random bytes with random CSN holds, last one releases CSN
        for (int i = 0; i < 6; i++) begin
            rtx[i] = 8'($urandom);
            rrs[i] = 8'($urandom);
            rh[i]  = (i < 5) ? 1'($urandom_range(1, 0)) : 1'b0;
            resp_q.push_back(rrs[i]);
        end
        prev_hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_byte(rtx[i], rh[i], rrs[i], prev_hold, 1'b0, 1'b0, "random");
            prev_hold = rh[i];
        end

        // Fastest timing, no GAP state
        tx_a = 8'($urandom);
        tx_b = 8'($urandom);
        @(negedge clk);
        miso2            = 1'b1;
        bus2.spi_start   = 1'b1;
        bus2.spi_tx_data = tx_a;
        bus2.spi_hold    = 1'b0;
        @(posedge clk);
        #1;
        check("fast", "accept_busy", bus2.spi_busy, 1);
        measure2(tx_a, 8'hFF, "fast_a");
        miso2            = 1'b0;
        bus2.spi_tx_data = tx_b;
        @(posedge clk);
        #1;
        check("fast", "reaccept_busy", bus2.spi_busy, 1);
        check("fast", "reaccept_csn", csn2, 0);
        bus2.spi_start = 1'b0;
        measure2(tx_b, 8'h00, "fast_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
